// File: rtl/seq_frac_mult_pkg.sv
// Shared sizing for the sequential fractional multiplier.
// The datapath width and the multiplier latency are the global parameters the controller uses.
`ifndef DATA_BUS_SIZE
`define DATA_BUS_SIZE 8
`endif
`ifndef MULT_LATENCY
`define MULT_LATENCY (`DATA_BUS_SIZE + 1)
`endif

package seq_frac_mult_pkg;
  localparam int unsigned DATA_BUS_SIZE = `DATA_BUS_SIZE;
  localparam int unsigned MULT_LATENCY  = `MULT_LATENCY;
endpackage

// File: rtl/seq_frac_mult_if.sv
// Start/done handshake between the picoMIPS controller and the sequential multiplier.
interface seq_frac_mult_if
  import seq_frac_mult_pkg::*;
#(
  parameter int unsigned N = DATA_BUS_SIZE
) ();
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic         ovf;

  modport master (output start, a, b, input busy, done, result, ovf);
  modport slave  (input start, a, b, output busy, done, result, ovf);
endinterface

// File: rtl/seq_frac_mult.sv
// Multi-cycle signed Q0.(n-1) x integer multiply, one multiplier bit per clock.
// Product is truncated (arithmetic shift right by n-1); ovf flags the single wrapping case.
module seq_frac_mult
  import seq_frac_mult_pkg::*;
#(
  parameter int unsigned n     = DATA_BUS_SIZE,
  parameter int unsigned cnt_w = $clog2(n) + 1
) (
  input  logic          clk,
  input  logic          n_reset,
  seq_frac_mult_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_q;
  logic [2*n-1:0]     acc_q;
  logic [2*n-1:0]     mcand_q;
  logic [n-1:0]       mplier_q;
  logic [cnt_w-1:0]   cnt_q;
  logic [n-1:0]       result_q;
  logic               ovf_q;
  logic               busy_q;
  logic               done_q;

  logic [2*n-1:0]     addend;
  logic [2*n-1:0]     acc_d;
  logic               last_step;

  // The multiplier MSB carries negative weight, so its partial product is subtracted.
  // The counter runs n-1..0 over the bits, then wraps negative for the result-capture edge.
  always_comb begin
    addend    = mplier_q[0] ? mcand_q : '0;
    acc_d     = (cnt_q == '0) ? (acc_q - addend) : (acc_q + addend);
    last_step = cnt_q[cnt_w-1];
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            mcand_q  <= {{n{bus.a[n-1]}}, bus.a};
            mplier_q <= bus.b;
            acc_q    <= '0;
            cnt_q    <= cnt_w'(n - 1);
            busy_q   <= 1'b1;
            state_q  <= CALC;
          end else begin
            state_q <= IDLE;
          end
        end
        CALC: begin
          if (last_step) begin
            result_q <= acc_q[2*n-2:n-1];
            ovf_q    <= acc_q[2*n-1] ^ acc_q[2*n-2];
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - cnt_w'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.ovf    = ovf_q;
endmodule

// File: tb/tb_seq_frac_mult.sv
// Scoreboard bench for seq_frac_mult: the driver queues expected results, a monitor checks each done.
module tb_seq_frac_mult;
  import seq_frac_mult_pkg::*;

  logic clk;
  logic n_reset;
  int   tests;
  int   fails;
  int   cyc;
  int   accepts;
  logic prev_done;

  logic [8:0] exp_q[$];
  int         acc_times[$];

  seq_frac_mult_if #(.N(8)) bus ();

  seq_frac_mult #(.n(8)) dut (
    .clk    (clk),
    .n_reset(n_reset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] model(input logic [7:0] ma, input logic [7:0] mb);
    logic signed [15:0] p;
    p = $signed(ma) * $signed(mb);
    return {p[14:7], p[15] ^ p[14]};
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (n_reset && bus.start && !bus.busy) begin
      acc_times.push_back(cyc + 1);
      accepts <= accepts + 1;
    end
  end

  always @(negedge clk) begin
    if (n_reset) begin
      if (bus.done) begin
        logic [8:0] e;
        int t;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_done: got result=%h ovf=%b, required no done", bus.result, bus.ovf);
        end else begin
          e = exp_q.pop_front();
          if (bus.result !== e[8:1] || bus.ovf !== e[0]) begin
            fails++;
            $display("FAIL result: got %h ovf=%b, required %h ovf=%b", bus.result, bus.ovf, e[8:1], e[0]);
          end
        end
        tests++;
        if (bus.busy || prev_done) begin
          fails++;
          $display("FAIL done_pulse: busy=%b prev_done=%b, required both 0", bus.busy, prev_done);
        end
        if (acc_times.size() != 0) begin
          t = acc_times.pop_front();
          tests++;
          if (cyc - t != 9) begin
            fails++;
            $display("FAIL latency: got %0d cycles, required 9", cyc - t);
          end
        end
      end
      prev_done <= bus.done;
    end
  end

  task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic [8:0] e);
    int w;
    w = 0;
    @(negedge clk);
    while (bus.busy && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) begin
      tests++;
      fails++;
      $display("FAIL issue_timeout: busy stuck at %b, required 0", bus.busy);
    end
    bus.a = ia;
    bus.b = ib;
    bus.start = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  initial begin
    logic [7:0] edges[8];
    int w;
    tests = 0; fails = 0; cyc = 0; accepts = 0; prev_done = 1'b0;
    edges = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'h81, 8'hFF, 8'h40, 8'hC0};
    bus.start = 1'b0; bus.a = '0; bus.b = '0;
    n_reset = 1'b0;
    #1;
    check("reset_outputs", {bus.result, bus.ovf}, 9'h000);
    check("reset_flags", {7'b0, bus.busy, bus.done}, 9'h000);
    #22 n_reset = 1'b1;

    issue(8'h60, 8'h08, {8'h06, 1'b0});
    issue(8'h40, 8'h10, {8'h08, 1'b0});
    issue(8'hC0, 8'h08, {8'hFC, 1'b0});
    issue(8'h60, 8'hF6, {8'hF8, 1'b0});
    issue(8'h40, 8'hFD, {8'hFE, 1'b0});
    issue(8'h80, 8'h80, {8'h80, 1'b1});
    drain();

    // Reset in the 4th CALC cycle: outputs clear at once and the request never completes.
    bus.a = 8'h60; bus.b = 8'h08; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2 n_reset = 1'b0;
    #1;
    check("midop_reset_outputs", {bus.result, bus.ovf}, 9'h000);
    check("midop_reset_flags", {7'b0, bus.busy, bus.done}, 9'h000);
    acc_times.delete();
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    repeat (20) @(negedge clk);

    issue(8'h80, 8'h7F, {8'h81, 1'b0});
    drain();

    // Start held high across three back-to-back operations.
    w = 0;
    while (bus.busy && w < 50) begin @(negedge clk); w++; end
    repeat (3) exp_q.push_back({8'h06, 1'b0});
    bus.a = 8'h60; bus.b = 8'h08; bus.start = 1'b1;
    w = accepts + 3;
    for (int i = 0; i < 60 && accepts < w; i++) @(negedge clk);
    bus.start = 1'b0;
    drain();

    // Operand changes and a stray start during CALC must not disturb the result.
    issue(8'hC0, 8'h08, {8'hFC, 1'b0});
    repeat (2) @(negedge clk);
    bus.a = 8'h7F; bus.b = 8'h7F; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    drain();

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("result_hold", {bus.result, bus.ovf}, {8'hFC, 1'b0});
    end

    for (int unsigned i = 0; i < 8; i++)
      for (int unsigned j = 0; j < 8; j++)
        issue(edges[i], edges[j], model(edges[i], edges[j]));
    for (int unsigned i = 0; i < 150; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom_range(255));
      rb = 8'($urandom_range(255));
      issue(ra, rb, model(ra, rb));
    end
    drain();
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
